// File: rtl/seq_pkg.sv
// Shared types for the RemoteComm command sequencer: FSM states, failure codes, index-width helper.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_SNT,
        WAIT_RESP,
        CHECK,
        NEXT,
        DONE
    } seq_state_t;

    typedef enum logic [1:0] {
        FC_NONE,
        FC_MISMATCH,
        FC_TIMEOUT
    } fail_code_t;

    // A single-entry table still needs a 1-bit index signal.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_timeout_cnt.sv
// Per-step timeout counter: cleared on clr, counts while en, flags the TMO_CYCLES-th enabled cycle.
module seq_timeout_cnt #(
    parameter int unsigned TMO_W      = 20,
    parameter int unsigned TMO_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TMO_W-1:0] LAST = TMO_W'(TMO_CYCLES - 1);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    // cnt_q holds the number of enabled cycles already elapsed, so the
    // expiring cycle is the TMO_CYCLES-th one spent waiting.
    assign expired = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rcom_cmd_sequencer.sv
// Table-driven RemoteComm command sequencer with per-step timeout and response check.
// Optional macro SEQ_STOP_ON_FAIL_EN: end the sequence at the first mismatch or timeout.
module rcom_cmd_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned CMD_W      = 16,
    parameter int unsigned RESP_W     = 8,
    parameter int unsigned TMO_W      = 20,
    parameter int unsigned TMO_CYCLES = 500000,
    localparam int unsigned IDX_W     = idx_width(DEPTH),
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tbl_we,
    input  logic [IDX_W-1:0]  tbl_addr,
    input  logic [CMD_W-1:0]  tbl_cmd,
    input  logic [RESP_W-1:0] tbl_exp,
    input  logic [CNT_W-1:0]  num_cmds,
    input  logic              start,
    output logic [CMD_W-1:0]  cmd,
    output logic              snd_cmd,
    input  logic              cmd_snt,
    input  logic              resp_rdy,
    input  logic [RESP_W-1:0] resp,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [IDX_W-1:0]  fail_idx,
    output logic [1:0]        fail_code,
    output logic [CNT_W-1:0]  pass_cnt
);

    seq_state_t        state_q;
    logic [CMD_W-1:0]  tbl_cmd_q [DEPTH];
    logic [RESP_W-1:0] tbl_exp_q [DEPTH];
    logic [CMD_W-1:0]  cmd_q;
    logic              snd_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [IDX_W-1:0]  step_q;
    logic [IDX_W-1:0]  fail_idx_q;
    fail_code_t        fail_code_q;
    logic [CNT_W-1:0]  pass_cnt_q;
    logic [CNT_W-1:0]  num_q;
    logic [RESP_W-1:0] resp_q;

    logic              tmo_clr;
    logic              tmo_en;
    logic              tmo_expired;
    logic [CNT_W-1:0]  num_clamped;
    logic              last_step;
    logic [IDX_W-1:0]  step_nxt;

    assign num_clamped = (num_cmds > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : num_cmds;
    assign last_step   = ((CNT_W'(step_q) + CNT_W'(1)) == num_q);
    assign step_nxt    = step_q + IDX_W'(1);
    assign tmo_clr     = (state_q == SEND);
    assign tmo_en      = (state_q == WAIT_SNT) || (state_q == WAIT_RESP);

    seq_timeout_cnt #(
        .TMO_W      (TMO_W),
        .TMO_CYCLES (TMO_CYCLES)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (tbl_we && !busy_q && (32'(tbl_addr) < DEPTH)) begin
            tbl_cmd_q[tbl_addr] <= tbl_cmd;
            tbl_exp_q[tbl_addr] <= tbl_exp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            snd_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            step_q      <= '0;
            fail_idx_q  <= '0;
            fail_code_q <= FC_NONE;
            pass_cnt_q  <= '0;
            num_q       <= '0;
            resp_q      <= '0;
        end else begin
            snd_q  <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        pass_cnt_q  <= '0;
                        fail_code_q <= FC_NONE;
                        fail_idx_q  <= '0;
                        pass_q      <= 1'b1;
                        step_q      <= '0;
                        num_q       <= num_clamped;
                        busy_q      <= 1'b1;
                        if (num_clamped == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= SEND;
                            snd_q   <= 1'b1;
                            cmd_q   <= tbl_cmd_q[0];
                        end
                    end
                end
                SEND: state_q <= WAIT_SNT;
                // Both wait states share one body: a response in WAIT_SNT only
                // counts alongside cmd_snt, and any event beats the timeout.
                WAIT_SNT, WAIT_RESP: begin
                    if (resp_rdy && (state_q == WAIT_RESP || cmd_snt)) begin
                        resp_q  <= resp;
                        state_q <= CHECK;
                    end else if (state_q == WAIT_SNT && cmd_snt) begin
                        state_q <= WAIT_RESP;
                    end else if (tmo_expired) begin
                        pass_q <= 1'b0;
                        if (fail_code_q == FC_NONE) begin
                            fail_code_q <= FC_TIMEOUT;
                            fail_idx_q  <= step_q;
                        end
`ifdef SEQ_STOP_ON_FAIL_EN
                        state_q <= DONE;
                        done_q  <= 1'b1;
`else
                        state_q <= NEXT;
`endif
                    end
                end
                CHECK: begin
                    if (resp_q == tbl_exp_q[step_q]) begin
                        pass_cnt_q <= pass_cnt_q + CNT_W'(1);
                        state_q    <= NEXT;
                    end else begin
                        pass_q <= 1'b0;
                        if (fail_code_q == FC_NONE) begin
                            fail_code_q <= FC_MISMATCH;
                            fail_idx_q  <= step_q;
                        end
`ifdef SEQ_STOP_ON_FAIL_EN
                        state_q <= DONE;
                        done_q  <= 1'b1;
`else
                        state_q <= NEXT;
`endif
                    end
                end
                NEXT: begin
                    if (last_step) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        step_q  <= step_nxt;
                        state_q <= SEND;
                        snd_q   <= 1'b1;
                        cmd_q   <= tbl_cmd_q[step_nxt];
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd       = cmd_q;
    assign snd_cmd   = snd_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_idx  = fail_idx_q;
    assign fail_code = fail_code_q;
    assign pass_cnt  = pass_cnt_q;

endmodule
